// File: rtl/fetch_queue.sv
// First-word-fall-through queue decoupling instruction fetch from decode.
// Holds {instruction, PC} pairs; a redirect flush discards every buffered entry.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_inst_valid,
    input  logic [31:0]              i_inst,
    input  logic [31:0]              i_fetch_pc,
    output logic                     o_ready,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_valid,
    output logic [31:0]              o_inst,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_pc_plus_4,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic [31:0]   last_pc;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [31:0] head_inst;
    logic [31:0] head_pc;

    // MSB of each pointer is the wrap bit distinguishing full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign o_ready = !full;
    assign o_valid = !empty && !i_flush;
    assign push    = i_inst_valid && !full && !i_flush;
    assign pop     = o_valid && !i_stall;

    assign head_inst = inst_mem[rd_ptr[AW-1:0]];
    assign head_pc   = pc_mem[rd_ptr[AW-1:0]];

    assign o_inst      = empty ? NOP_INST : head_inst;
    assign o_pc        = empty ? last_pc : head_pc;
    assign o_pc_plus_4 = o_pc + 32'd4;
    assign o_count     = count_q;
    assign o_empty     = empty;
    assign o_full      = full;

    // Pointer, occupancy and last-consumed-PC state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            last_pc <= '0;
        end else if (i_flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                last_pc <= head_pc;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only slots behind valid pointers are ever read out
    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[wr_ptr[AW-1:0]] <= i_inst;
            pc_mem[wr_ptr[AW-1:0]]   <= i_fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected {inst, pc} pairs are queued at issue
// and a negedge monitor checks every consumed head entry against them.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] fetch_pc;
    logic        ready;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] q_inst;
    logic [31:0] q_pc;
    logic [31:0] q_pc4;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sbq [$];

    fetch_queue #(.DEPTH(4), .NOP_INST(32'h00000013)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst_valid (inst_valid),
        .i_inst       (inst),
        .i_fetch_pc   (fetch_pc),
        .o_ready      (ready),
        .i_stall      (stall),
        .i_flush      (flush),
        .o_valid      (valid),
        .o_inst       (q_inst),
        .o_pc         (q_pc),
        .o_pc_plus_4  (q_pc4),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every head entry consumed by decode must match the oldest expected pair
    always @(negedge clk) begin
        if (rst_n && valid && !stall) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h with nothing expected", q_pc);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                chk("pop_inst", q_inst, e[63:32]);
                chk("pop_pc", q_pc, e[31:0]);
                chk("pop_pc4", q_pc4, e[31:0] + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word that is accepted at the next edge (queue known not full)
    task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
        inst_valid = 1'b1;
        inst       = w;
        fetch_pc   = pc;
        sbq.push_back({w, pc});
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1;
        end
        chk(name, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst = '0; fetch_pc = '0;
        stall = 1'b0; flush = 1'b0;

        // Reset then idle
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_inst", q_inst, 32'h00000013);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pc", q_pc, 32'h0);
        chk("rst_pc4", q_pc4, 32'h4);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        tick();

        // Single pass-through with one-cycle latency
        push_one(32'h00500093, 32'h100);
        @(negedge clk);
        chk("pt_valid", 32'(valid), 32'd1);
        chk("pt_inst", q_inst, 32'h00500093);
        chk("pt_pc4", q_pc4, 32'h104);
        chk("pt_count", 32'(count), 32'd1);
        tick();
        @(negedge clk);
        chk("pt_valid_after", 32'(valid), 32'd0);
        chk("pt_count_after", 32'(count), 32'd0);
        chk("pt_inst_nop", q_inst, 32'h00000013);
        chk("pt_pc_hold", q_pc, 32'h100);
        tick();

        // Fill under stall, then backpressure on a fifth word
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_one(32'hA0000000 | 32'(i), 32'(i * 4));
        inst_valid = 1'b1; inst = 32'hA0000004; fetch_pc = 32'h10;
        sbq.push_back({32'hA0000004, 32'h10});
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(ready), 32'd0);
        chk("fill_count", 32'(count), 32'd4);
        tick();
        @(negedge clk);
        chk("fill_blocked_count", 32'(count), 32'd4);
        tick();
        stall = 1'b0;
        begin
            bit acc;
            acc = 0;
            for (int i = 0; i < 20 && !acc; i++) begin
                @(negedge clk);
                if (ready) acc = 1;
            end
            chk("fill_accept", 32'(acc), 32'd1);
            tick();
            inst_valid = 1'b0;
        end
        drain("fill_drain");

        // Simultaneous push and pop at occupancy 2 across pointer wrap
        stall = 1'b1;
        push_one(32'hB0000000, 32'h300);
        push_one(32'hB0000001, 32'h304);
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            inst_valid = 1'b1;
            inst       = 32'hB0000002 + 32'(k);
            fetch_pc   = 32'h308 + 32'(4 * k);
            sbq.push_back({inst, fetch_pc});
            @(negedge clk);
            chk("pp_count", 32'(count), 32'd2);
            tick();
        end
        inst_valid = 1'b0;
        @(negedge clk);
        chk("pp_count_end", 32'(count), 32'd2);
        tick();
        drain("pp_drain");

        // Flush with a concurrent push that must be dropped
        stall = 1'b1;
        push_one(32'hC0000000, 32'h400);
        push_one(32'hC0000001, 32'h404);
        push_one(32'hC0000002, 32'h408);
        flush = 1'b1; inst_valid = 1'b1; inst = 32'hC0000200; fetch_pc = 32'h200;
        sbq.delete();
        @(negedge clk);
        chk("fl_valid", 32'(valid), 32'd0);
        chk("fl_count_before", 32'(count), 32'd3);
        tick();
        flush = 1'b0; inst_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_valid_after", 32'(valid), 32'd0);
        tick(); tick();

        // Asynchronous reset between edges
        stall = 1'b1;
        push_one(32'hD0000000, 32'h500);
        push_one(32'hD0000001, 32'h504);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_inst", q_inst, 32'h00000013);
        chk("ar_pc", q_pc, 32'h0);
        tick();
        rst_n = 1'b1; stall = 1'b0;
        push_one(32'hE0000000, 32'h600);
        @(negedge clk);
        chk("ar_post_valid", 32'(valid), 32'd1);
        chk("ar_post_count", 32'(count), 32'd1);
        chk("ar_post_pc", q_pc, 32'h600);
        tick();
        drain("ar_drain");

        chk("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the IF stage and the ID stage.
- Accepts fetched instruction/PC pairs through a valid/ready handshake and presents the oldest entry to ID in first-word-fall-through order.
- Absorbs instruction-cache miss latency and ID stalls.
- Discards all buffered entries on a branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- NOP_INST, 32'h00000013, instruction word driven on o_inst when the queue is empty (addi x0,x0,0).

Ports:
- i_clk  input  1  global clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_inst_valid  input  1  IF presents a valid instruction.
- i_inst  input  32  instruction word from IF.
- i_fetch_pc  input  32  PC of i_inst.
- o_ready  output  1  queue can accept a write this cycle.
- i_stall  input  1  ID/hazard unit stall; head entry must not be consumed.
- i_flush  input  1  redirect/flush; discard all entries.
- o_valid  output  1  head entry valid for ID.
- o_inst  output  32  head instruction word.
- o_pc  output  32  head PC.
- o_pc_plus_4  output  32  o_pc + 4, modulo 2^32.
- o_count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- o_empty  output  1  o_count == 0.
- o_full  output  1  o_count == DEPTH.

Behaviour:
- Reset (i_rst_n low, asynchronous assert, synchronous release on clock edge):
  - write pointer, read pointer and count = 0.
  - o_valid=0, o_empty=1, o_full=0, o_ready=1, o_count=0.
  - o_inst=NOP_INST, o_pc=0, o_pc_plus_4=4.
  - Storage array contents need not be reset.
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB as wrap bit:
  - empty when the pointers are equal;
  - full when the low bits are equal and the MSBs differ.
  - Pointers increment modulo 2*DEPTH.
- o_ready = !o_full; purely a function of registered state, with no combinational path from i_stall or i_flush.
- push = i_inst_valid && o_ready && !i_flush. On push, {i_inst, i_fetch_pc} is written at the write pointer, and the write pointer increments at the clock edge.
- pop = o_valid && !i_stall. On pop, the read pointer increments at the clock edge.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
- When full, push is blocked even if pop occurs in the same cycle. IF holds i_inst_valid/i_inst/i_fetch_pc steady until o_ready=1.
- Output path (first-word fall-through):
  - o_valid = !o_empty && !i_flush.
  - o_inst/o_pc come combinationally from the entry at the read pointer.
  - A write into an empty queue is visible on o_valid the cycle after the push edge, so minimum latency IF→ID is 1 cycle.
  - When empty: o_inst=NOP_INST, o_pc holds the last popped PC (0 after reset).
- Flush (i_flush=1):
  - At the clock edge, the read pointer is set equal to the write pointer and count becomes 0.
  - Any push presented in that cycle is dropped; any pop is irrelevant.
  - o_valid is forced 0 during the flush cycle.
  - Flush has priority over push, pop and stall.
- Flush while empty: no effect except that the same-cycle push is dropped.
- Stall while empty: no effect; pushes continue until full.
- Reset mid-operation: all entries discarded immediately, with outputs at reset values while i_rst_n is low.
- o_count is registered: +1 on push-only, -1 on pop-only, unchanged on both/neither, 0 on flush.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 2 cycles with i_inst_valid=0, then release → o_valid=0, o_inst=32'h00000013, o_ready=1, o_count=0, o_pc_plus_4=4.
- Single pass-through: push {i_inst=32'h00500093, pc=32'h100} with i_stall=0 → next cycle o_valid=1, o_inst=32'h00500093, o_pc=32'h100, o_pc_plus_4=32'h104; following cycle o_valid=0, o_count=0.
- Fill and backpressure: i_stall=1, push PCs 0x0,0x4,0x8,0xC → o_full=1, o_ready=0, o_count=4; a fifth offered word at PC 0x10 is not accepted. Release stall → words pop in order 0x0,0x4,0x8,0xC, then 0x10 is accepted and popped.
- Simultaneous push/pop: with count=2, push and pop on 6 consecutive cycles → count stays 2 and PC order is preserved across pointer wrap-around.
- Flush with push: count=3, assert i_flush together with i_inst_valid carrying PC 0x200 → o_valid=0 that cycle; next cycle o_count=0, o_empty=1; PC 0x200 never appears on o_pc.
- Async reset mid-stream: count=2, drop i_rst_n between clock edges → o_valid and o_count go to 0 before the next rising edge; after release, the next push appears as the only entry.
